step_counter: RTL and testbench
===============================

STEP_COUNTER -- requirements
Module: step_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 6: count register width in bits.
REQ-002 SHALL have parameter TERMINAL, default 32: RUN cycles per operation; legal range 1..2^WIDTH.
REQ-003 SHALL have parameter DOWN, default 0: 0 = count up 0..TERMINAL-1; 1 = count down TERMINAL-1..0.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port clr, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port start, input, 1 bit: begins an operation; sampled in IDLE and DONE only.
REQ-007 SHALL have port stall, input, 1 bit: freezes count and state while in RUN.
REQ-008 SHALL have port abort, input, 1 bit: cancels a RUN operation.
REQ-009 SHALL have port count, output, WIDTH bits: current step index.
REQ-010 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-011 SHALL have port last, output, 1 bit: high in RUN when count equals the final index.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 SHALL implement three states: IDLE, RUN, DONE.
REQ-014 SHALL define first index FI = 0 (DOWN=0) or TERMINAL-1 (DOWN=1), and final index LI = TERMINAL-1 (DOWN=0) or 0 (DOWN=1).
REQ-015 IDLE: count = 0; busy = 0; done = 0; on start=1 -> RUN with count = FI at the next edge.
REQ-016 RUN, priority abort > stall > step: abort=1 -> IDLE, count = 0, no done pulse.
REQ-017 RUN, stall=1 and abort=0: state and count hold.
REQ-018 RUN, no stall, count != LI: count increments (DOWN=0) or decrements (DOWN=1) by 1.
REQ-019 RUN, no stall, count == LI: -> DONE, count = 0.
REQ-020 DONE: done = 1 and busy = 0 for exactly one cycle; start=1 -> RUN with count = FI (back-to-back); otherwise -> IDLE.
REQ-021 start SHALL be ignored in RUN.
REQ-022 last SHALL equal busy AND (count == LI), decoded from registered state only; with TERMINAL=1, last is high in the single RUN cycle.
REQ-023 Without stalls, start sampled at edge k SHALL give busy over edges k+1..k+TERMINAL and done high between edges k+TERMINAL and k+TERMINAL+1.
REQ-024 Each stall cycle in RUN SHALL delay done by exactly one cycle.
REQ-025 count SHALL never leave the range 0..TERMINAL-1 and never wrap modulo 2^WIDTH; TERMINAL = 2^WIDTH SHALL be handled without overflow.
REQ-026 All outputs SHALL be registered or decoded from registered state, with no combinational path from any input.

Reset
REQ-027 clr=0 SHALL immediately, without waiting for a clock edge, force state IDLE, count = 0, busy = 0, last = 0, done = 0.
REQ-028 Reset asserted mid-RUN or in DONE SHALL discard the operation; no done pulse follows.
REQ-029 After clr returns to 1, the first edge SHALL sample start normally.

Verification
REQ-030 Defaults; start pulsed 1 cycle -> count 0,1,..,31 with busy=1 for 32 cycles; last=1 only at count=31; then done=1 for 1 cycle and count=0.
REQ-031 DOWN=1, TERMINAL=5; start -> count 4,3,2,1,0; last at 0; done on the 6th edge after start.
REQ-032 Defaults; stall held 3 cycles at count=10 -> count stays 10; done 3 cycles later than REQ-030.
REQ-033 Abort at count=7 together with stall=1 -> IDLE next edge, count=0, busy=0, no done pulse.
REQ-034 start held high continuously, TERMINAL=4 -> RUN(4 cycles)/DONE(1 cycle) repeats; done every 5 cycles; start ignored during RUN.
REQ-035 clr driven low between edges at count=20 -> count=0 and busy=0 with no clock edge; no done pulse after release; TERMINAL=1 and WIDTH=2/TERMINAL=4 corner runs give correct last and done.

Source files
------------

// File: rtl/step_counter.sv
// Stepped operation counter: IDLE -> RUN (TERMINAL steps) -> DONE pulse.
// Ports: clock, clr (async low), start/stall/abort in; count/busy/last/done out.
module step_counter #(
  parameter int WIDTH    = 6,
  parameter int TERMINAL = 32,
  parameter int DOWN     = 0
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             start,
  input  logic             stall,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             last,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // TERMINAL-1 always fits in WIDTH bits, even at TERMINAL = 2^WIDTH.
  localparam logic [WIDTH-1:0] TOP = WIDTH'(TERMINAL - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] FI  = (DOWN != 0) ? TOP : '0;
  localparam logic [WIDTH-1:0] LI  = (DOWN != 0) ? '0 : TOP;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          count_d = FI;
        end else begin
          state_d = S_IDLE;
          count_d = '0;
        end
      end
      S_RUN: begin
        // abort beats stall beats stepping
        if (abort) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (stall) begin
          state_d = S_RUN;
        end else if (count_q == LI) begin
          state_d = S_DONE;
          count_d = '0;
        end else if (DOWN != 0) begin
          count_d = count_q - ONE;
        end else begin
          count_d = count_q + ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    last = (state_q == S_RUN) && (count_q == LI);
  end

  assign count = count_q;

endmodule

// File: tb/tb_step_counter.sv
// Directed bench for step_counter over several parameter sets.
// Outputs are packed as {count, busy, last, done} and checked #1 after edges.
module tb_step_counter;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic abort = 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [5:0] c_def, c_dn5, c_t4;
  logic [0:0] c_t1;
  logic [1:0] c_w2, c_w2d;
  logic b_def, l_def, d_def;
  logic b_dn5, l_dn5, d_dn5;
  logic b_t4, l_t4, d_t4;
  logic b_t1, l_t1, d_t1;
  logic b_w2, l_w2, d_w2;
  logic b_w2d, l_w2d, d_w2d;

  step_counter u_def (
    .clock(clk), .clr(clr), .start(start),
    .stall(stall), .abort(abort),
    .count(c_def), .busy(b_def),
    .last(l_def), .done(d_def)
  );
  step_counter #(.WIDTH(6), .TERMINAL(5), .DOWN(1)) u_dn5 (
    .clock(clk), .clr(clr), .start(start),
    .stall(stall), .abort(abort),
    .count(c_dn5), .busy(b_dn5),
    .last(l_dn5), .done(d_dn5)
  );
  step_counter #(.WIDTH(6), .TERMINAL(4), .DOWN(0)) u_t4 (
    .clock(clk), .clr(clr), .start(start),
    .stall(stall), .abort(abort),
    .count(c_t4), .busy(b_t4),
    .last(l_t4), .done(d_t4)
  );
  step_counter #(.WIDTH(1), .TERMINAL(1), .DOWN(0)) u_t1 (
    .clock(clk), .clr(clr), .start(start),
    .stall(stall), .abort(abort),
    .count(c_t1), .busy(b_t1),
    .last(l_t1), .done(d_t1)
  );
  step_counter #(.WIDTH(2), .TERMINAL(4), .DOWN(0)) u_w2 (
    .clock(clk), .clr(clr), .start(start),
    .stall(stall), .abort(abort),
    .count(c_w2), .busy(b_w2),
    .last(l_w2), .done(d_w2)
  );
  step_counter #(.WIDTH(2), .TERMINAL(4), .DOWN(1)) u_w2d (
    .clock(clk), .clr(clr), .start(start),
    .stall(stall), .abort(abort),
    .count(c_w2d), .busy(b_w2d),
    .last(l_w2d), .done(d_w2d)
  );

  logic [8:0] o_def, o_dn5, o_t4, o_t1, o_w2, o_w2d;
  assign o_def = {c_def, b_def, l_def, d_def};
  assign o_dn5 = {c_dn5, b_dn5, l_dn5, d_dn5};
  assign o_t4  = {c_t4, b_t4, l_t4, d_t4};
  assign o_t1  = {5'd0, c_t1, b_t1, l_t1, d_t1};
  assign o_w2  = {4'd0, c_w2, b_w2, l_w2, d_w2};
  assign o_w2d = {4'd0, c_w2d, b_w2d, l_w2d, d_w2d};

  function automatic logic [8:0] ex(int c, logic b,
                                    logic l, logic d);
    logic [5:0] cc;
    cc = 6'(c);
    return {cc, b, l, d};
  endfunction

  task automatic chk(string nm, logic [8:0] act,
                     logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got cnt=%0d b/l/d=%b want cnt=%0d b/l/d=%b",
               nm, act[8:3], act[2:0], exp[8:3], exp[2:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    clr   = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
    #1;
    chk("rst_def", o_def, ex(0, 0, 0, 0));
    chk("rst_dn5", o_dn5, ex(0, 0, 0, 0));
    step();
    clr = 1'b1;
  endtask

  typedef struct {
    logic st, sl, ab;
    int   c;
    logic b, l, d;
  } vec_t;

  vec_t tbl[18];
  logic seen;
  int   p;

  initial begin
    tbl = '{
      '{0, 0, 1, 0, 0, 0, 0},
      '{1, 0, 0, 0, 1, 0, 0},
      '{1, 0, 0, 1, 1, 0, 0},
      '{0, 1, 0, 1, 1, 0, 0},
      '{0, 0, 0, 2, 1, 0, 0},
      '{0, 0, 0, 3, 1, 1, 0},
      '{0, 1, 0, 3, 1, 1, 0},
      '{0, 0, 0, 0, 0, 0, 1},
      '{1, 0, 0, 0, 1, 0, 0},
      '{0, 0, 0, 1, 1, 0, 0},
      '{0, 1, 1, 0, 0, 0, 0},
      '{0, 0, 0, 0, 0, 0, 0},
      '{1, 0, 0, 0, 1, 0, 0},
      '{0, 0, 0, 1, 1, 0, 0},
      '{0, 0, 0, 2, 1, 0, 0},
      '{0, 0, 0, 3, 1, 1, 0},
      '{0, 0, 0, 0, 0, 0, 1},
      '{0, 1, 0, 0, 0, 0, 0}
    };

    // async reset visible before any clock edge
    #1;
    chk("rst_t0", o_def, ex(0, 0, 0, 0));

    // table on TERMINAL=4
    do_reset();
    for (int i = 0; i < 18; i++) begin
      start = tbl[i].st;
      stall = tbl[i].sl;
      abort = tbl[i].ab;
      step();
      chk($sformatf("tbl[%0d]", i), o_t4,
          ex(tbl[i].c, tbl[i].b, tbl[i].l, tbl[i].d));
    end
    start = 0; stall = 0; abort = 0;

    // default full run
    do_reset();
    start = 1;
    for (int i = 0; i < 32; i++) begin
      step();
      start = 0;
      chk("run32", o_def, ex(i, 1, i == 31, 0));
    end
    step();
    chk("run32_done", o_def, ex(0, 0, 0, 1));
    step();
    chk("run32_idle", o_def, ex(0, 0, 0, 0));

    // stall 3 cycles at count 10
    do_reset();
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 10; i++) step();
    chk("stl_at10", o_def, ex(10, 1, 0, 0));
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_hold", o_def, ex(10, 1, 0, 0));
    end
    stall = 0;
    for (int k = 0; k < 22; k++) begin
      step();
      if (k < 21)
        chk("stl_run", o_def, ex(11 + k, 1, k == 20, 0));
      else
        chk("stl_done", o_def, ex(0, 0, 0, 1));
    end

    // DOWN=1 TERMINAL=5
    do_reset();
    start = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      start = 0;
      chk("dn5", o_dn5, ex(4 - i, 1, i == 4, 0));
    end
    step();
    chk("dn5_done", o_dn5, ex(0, 0, 0, 1));

    // abort together with stall at count 7
    do_reset();
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 7; i++) step();
    chk("abt_at7", o_def, ex(7, 1, 0, 0));
    abort = 1;
    stall = 1;
    step();
    chk("abt_idle", o_def, ex(0, 0, 0, 0));
    abort = 0;
    stall = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (d_def) seen = 1;
    end
    chk("abt_nodone", {8'd0, seen}, 9'd0);

    // continuous start, TERMINAL=4
    do_reset();
    start = 1;
    for (int i = 1; i <= 15; i++) begin
      step();
      p = (i - 1) % 5;
      if (p < 4)
        chk("cont_run", o_t4, ex(p, 1, p == 3, 0));
      else
        chk("cont_done", o_t4, ex(0, 0, 0, 1));
    end
    start = 0;

    // async clr between edges mid-run
    do_reset();
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 20; i++) step();
    chk("clr_at20", o_def, ex(20, 1, 0, 0));
    #2;
    clr = 0;
    #1;
    chk("clr_async", o_def, ex(0, 0, 0, 0));
    step();
    clr = 1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (d_def || b_def) seen = 1;
    end
    chk("clr_nodone", {8'd0, seen}, 9'd0);
    start = 1;
    step();
    start = 0;
    chk("clr_restart", o_def, ex(0, 1, 0, 0));

    // TERMINAL=1
    do_reset();
    start = 1;
    step();
    start = 0;
    chk("t1_run", o_t1, ex(0, 1, 1, 0));
    step();
    chk("t1_done", o_t1, ex(0, 0, 0, 1));
    step();
    chk("t1_idle", o_t1, ex(0, 0, 0, 0));

    // WIDTH=2 TERMINAL=4, up and down
    do_reset();
    start = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      start = 0;
      chk("w2_up", o_w2, ex(i, 1, i == 3, 0));
      chk("w2_dn", o_w2d, ex(3 - i, 1, i == 3, 0));
    end
    step();
    chk("w2_up_done", o_w2, ex(0, 0, 0, 1));
    chk("w2_dn_done", o_w2d, ex(0, 0, 0, 1));
    step();
    chk("w2_idle", o_w2, ex(0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
